draw_pair_sequencer: RTL and testbench
======================================

# draw_pair_sequencer

Controller for the draw path's paired-address memory port. Accepts fill/draw commands from two requesters over valid/ready handshakes and arbitrates between them. For the granted command, it sequences a run of even/odd address pairs, one pair per cycle, under downstream back-pressure. Each completed run ends with a per-requester done pulse.

## Interface
Parameters:
- PAIR_W, 13, width of pair index; addresses are PAIR_W+1 bits
- LEN_W, 8, width of run length in pairs

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_base  in  PAIR_W  requester 0 starting pair index
- req0_len  in  LEN_W  requester 0 run length in pairs
- req0_ready  out  1  requester 0 command accepted this cycle
- req1_valid / req1_base / req1_len / req1_ready  same as requester 0, for requester 1
- mem_ready  in  1  downstream accepts the current pair
- mem_en  out  1  Q_a/Q_b valid
- Q_a  out  PAIR_W+1  even address {idx, 1'b0}
- Q_b  out  PAIR_W+1  odd address {idx, 1'b1}
- owner  out  1  requester whose run is in progress
- busy  out  1  high in RUN and DONE
- done0, done1  out  1  one-cycle completion pulse per requester

## Operation
- FSM states:
  - IDLE: no run in progress.
  - RUN: pairs are issued.
  - DONE: one cycle, emits the completion pulse.
- IDLE:
  - The arbiter picks one requester among those with valid high.
  - Only the winner's ready is driven high, combinationally, in the same cycle.
  - On the handshake, latch idx←base, remaining←len, owner←winner.
  - If len≠0, go to RUN.
  - If len=0, go straight to DONE; no pairs are issued.
- RUN:
  - mem_en=1; Q_a/Q_b come from idx.
  - If mem_ready=1, the pair is consumed: idx←idx+1 (mod 2^PAIR_W, wraps silently) and remaining←remaining−1.
  - If a pair is consumed while remaining=1, go to DONE.
  - If mem_ready=0, idx, remaining and the outputs hold.
- DONE: done_owner=1 for exactly one cycle, then go to IDLE.
- Both ready outputs are 0 outside IDLE. Valid requests in those states wait; they are not dropped.
- Q_a/Q_b hold their last value when mem_en=0.
- Arbitration when both valids are high: the requester not granted most recently wins (last_grant resets to 1, so requester 0 wins the first tie). A single valid requester always wins.
- Outputs after reset:
  - mem_en, req*_ready, done*, busy, owner = 0.
  - Q_a=0, Q_b=1.
  - State is IDLE.
- Reset asserted mid-run: the run is aborted at that clock edge. No done pulse is emitted and the command is not retried.

## Timing
- Handshake in cycle N → first pair on Q_a/Q_b with mem_en=1 in cycle N+1.
- Throughput is 1 pair/cycle with mem_ready held high, so a len=L run occupies RUN for exactly L cycles.
- done pulses in the cycle after the last consumed pair. The earliest next handshake is the cycle after done, giving a 2-cycle gap between runs.
- len=0: handshake in N, done in N+1, next grant possible in N+2.
- req*_base and req*_len are sampled only in the handshake cycle.

## Configuration
- DRAW_PAIR_SEQ_RR_EN defined: round-robin arbitration as described above.
- DRAW_PAIR_SEQ_RR_EN undefined: fixed priority. Requester 0 always wins ties, and the last_grant register is not built.

## Test plan
- Reset, then req0 base=3584 len=128, mem_ready=1 → 128 pairs: Q_a 7168,7170,…,7422 and Q_b 7169,…,7423; done0 in the cycle after the last pair; done1 never.
- req0 base=8190 len=4 with mem_ready low on the 2nd and 3rd pair → idx sequence 8190,8191,0,1 with each stalled pair held steady; total RUN time 6 cycles.
- req0 and req1 valid continuously, len=2 each:
  - With RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: all grants go to 0 while req0 stays valid.
- req1 len=0 → ready1 in cycle N, done1 in N+1, mem_en never asserted.
- Reset pulled low in the 5th RUN cycle of a len=20 run → next cycle shows IDLE, mem_en=0, Q_a=0, Q_b=1, no done; a new req0 command is then accepted normally.

Source files
------------

// File: rtl/draw_pair_sequencer.sv
// Two-requester paired-address sequencer: arbitrates fill/draw commands and issues even/odd address pairs.
// Define DRAW_PAIR_SEQ_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module draw_pair_sequencer #(
  parameter int PAIR_W = 13,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [PAIR_W-1:0] req0_base,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [PAIR_W-1:0] req1_base,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  input  logic              mem_ready,
  output logic              mem_en,
  output logic [PAIR_W:0]   Q_a,
  output logic [PAIR_W:0]   Q_b,
  output logic              owner,
  output logic              busy,
  output logic              done0,
  output logic              done1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAIR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               owner_q, owner_d;
  logic               win_s;
  logic               accept_s;
  logic [PAIR_W-1:0]  base_s;
  logic [LEN_W-1:0]   len_s;
`ifdef DRAW_PAIR_SEQ_RR_EN
  logic               last_grant_q, last_grant_d;
`endif

  // Arbitration: a lone requester always wins; ties go to the one not granted last (or req0).
  always_comb begin
    win_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef DRAW_PAIR_SEQ_RR_EN
      win_s = ~last_grant_q;
`else
      win_s = 1'b0;
`endif
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Ready is suppressed while reset is held so no command is swallowed by an aborted cycle.
  assign accept_s   = (state_q == S_IDLE) && reset && (req0_valid || req1_valid);
  assign req0_ready = accept_s && !win_s;
  assign req1_ready = accept_s && win_s;
  assign base_s     = win_s ? req1_base : req0_base;
  assign len_s      = win_s ? req1_len  : req0_len;

  // Next-state logic; idx only advances when another pair follows, so Q holds the last issued pair.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    owner_d = owner_q;
`ifdef DRAW_PAIR_SEQ_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          owner_d = win_s;
          rem_d   = len_s;
`ifdef DRAW_PAIR_SEQ_RR_EN
          last_grant_d = win_s;
`endif
          if (len_s != {LEN_W{1'b0}}) begin
            idx_d   = base_s;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (mem_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + PAIR_W'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; a reset mid-run drops the command.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= {PAIR_W{1'b0}};
      rem_q   <= {LEN_W{1'b0}};
      owner_q <= 1'b0;
`ifdef DRAW_PAIR_SEQ_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
`ifdef DRAW_PAIR_SEQ_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_en = (state_q == S_RUN);
  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign owner  = owner_q;
  assign done0  = (state_q == S_DONE) && !owner_q;
  assign done1  = (state_q == S_DONE) && owner_q;
  assign Q_a    = {idx_q, 1'b0};
  assign Q_b    = {idx_q, 1'b1};

endmodule

// File: tb/tb_draw_pair_sequencer.sv
// Randomized and directed bench for draw_pair_sequencer against a cycle-level behavioural model.
module tb_draw_pair_sequencer;
  localparam int PAIR_W = 13;
  localparam int LEN_W  = 8;
  localparam int NPAIR  = 1 << PAIR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [PAIR_W-1:0] req0_base, req1_base;
  logic [LEN_W-1:0]  req0_len, req1_len;
  logic              mem_ready, mem_en, owner, busy, done0, done1;
  logic [PAIR_W:0]   Q_a, Q_b;

  draw_pair_sequencer #(.PAIR_W(PAIR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_base(req0_base), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_base(req1_base), .req1_len(req1_len), .req1_ready(req1_ready),
    .mem_ready(mem_ready), .mem_en(mem_en), .Q_a(Q_a), .Q_b(Q_b),
    .owner(owner), .busy(busy), .done0(done0), .done1(done1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 = waiting for command, 1 = issuing pairs, 2 = completion cycle.
  int m_phase, m_owner, m_last, m_q, m_left, m_runcyc;
  bit p_v[2];
  int p_base[2], p_len[2], refill[2];
  int obs_grants[$];
  int mem_en_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s: cycle budget exhausted", tag);
  endtask

  function automatic int pick();
    if (p_v[0] && p_v[1]) begin
`ifdef DRAW_PAIR_SEQ_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    if (p_v[0]) return 0;
    if (p_v[1]) return 1;
    return -1;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_q = 0; m_last = 1; m_left = 0; m_runcyc = 0;
  endfunction

  // One clock cycle: entered and left at a negedge.
  task automatic step();
    int w;
    req0_valid = p_v[0]; req0_base = PAIR_W'(p_base[0]); req0_len = LEN_W'(p_len[0]);
    req1_valid = p_v[1]; req1_base = PAIR_W'(p_base[1]); req1_len = LEN_W'(p_len[1]);
    #1;
    w = (m_phase == 0 && reset) ? pick() : -1;
    check_eq("ready0", 32'(req0_ready), 32'(w == 0));
    check_eq("ready1", 32'(req1_ready), 32'(w == 1));
    check_eq("mem_en", 32'(mem_en), 32'(m_phase == 1));
    check_eq("busy",   32'(busy),   32'(m_phase != 0));
    check_eq("owner",  32'(owner),  32'(m_owner));
    check_eq("done0",  32'(done0),  32'(m_phase == 2 && m_owner == 0));
    check_eq("done1",  32'(done1),  32'(m_phase == 2 && m_owner == 1));
    check_eq("Q_a",    32'(Q_a),    32'(m_q * 2));
    check_eq("Q_b",    32'(Q_b),    32'(m_q * 2 + 1));
    if (req0_ready && req0_valid) obs_grants.push_back(0);
    if (req1_ready && req1_valid) obs_grants.push_back(1);
    if (mem_en) mem_en_cycles++;
    if (!reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (w >= 0) begin
        m_owner = w; m_last = w; m_runcyc = 0;
        if (p_len[w] != 0) begin
          m_phase = 1; m_q = p_base[w]; m_left = p_len[w];
        end else begin
          m_phase = 2;
        end
        p_v[w] = refill[w] != 0;
        if (refill[w] == 2) begin
          p_base[w] = int'($urandom_range(NPAIR - 1, 0));
          p_len[w]  = int'($urandom_range(6, 0));
        end
      end
    end else if (m_phase == 1) begin
      m_runcyc++;
      if (mem_ready) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
        else m_q = (m_q + 1) % NPAIR;
      end
    end else begin
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while ((m_phase != 0 || p_v[0] || p_v[1]) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) bound_fail(tag);
    repeat (2) step();
  endtask

  task automatic post(input int k, input int base, input int len);
    p_v[k] = 1'b1; p_base[k] = base; p_len[k] = len;
  endtask

  initial begin
    int e0;
    int n;
    reset = 1'b0; mem_ready = 1'b0;
    p_v[0] = 1'b0; p_v[1] = 1'b0; refill[0] = 0; refill[1] = 0;
    p_base[0] = 0; p_base[1] = 0; p_len[0] = 0; p_len[1] = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    step();
    reset = 1'b1;
    step();

    // Long run with no back-pressure.
    mem_ready = 1'b1;
    post(0, 3584, 128);
    e0 = mem_en_cycles;
    drain("long_run", 300);
    check_eq("long_run_pairs", 32'(mem_en_cycles - e0), 32'd128);

    // Wrapping run with stalls on the 2nd and 3rd pair.
    post(0, 8190, 4);
    e0 = mem_en_cycles;
    n = 0;
    while ((m_phase != 0 || p_v[0]) && n < 40) begin
      mem_ready = (m_phase == 1 && (m_runcyc == 1 || m_runcyc == 3)) ? 1'b0 : 1'b1;
      step();
      n++;
    end
    if (n >= 40) bound_fail("wrap_run");
    mem_ready = 1'b1;
    repeat (2) step();
    check_eq("wrap_run_cycles", 32'(mem_en_cycles - e0), 32'd6);

    // Continuous contention, len=2 each, from a fresh reset.
    reset = 1'b0; step(); reset = 1'b1;
    obs_grants.delete();
    refill[0] = 1; refill[1] = 1;
    post(0, 10, 2); post(1, 200, 2);
    n = 0;
    while (obs_grants.size() < 4 && n < 100) begin step(); n++; end
    if (n >= 100) bound_fail("contention");
    refill[0] = 0; refill[1] = 0;
    if (m_phase == 0) begin p_v[0] = 1'b0; p_v[1] = 1'b0; end
    drain("contention_drain", 40);
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DRAW_PAIR_SEQ_RR_EN
      check_eq("grant_order", 32'(obs_grants[i]), 32'(i % 2));
`else
      check_eq("grant_order", 32'(obs_grants[i]), 32'd0);
`endif
    end

    // Zero-length command from requester 1.
    post(1, 77, 0);
    e0 = mem_en_cycles;
    drain("len0", 20);
    check_eq("len0_no_pairs", 32'(mem_en_cycles - e0), 32'd0);

    // Reset asserted during the 5th RUN cycle of a len=20 run.
    post(0, 100, 20);
    n = 0;
    while (n < 40) begin
      if (m_phase == 1 && m_runcyc == 4) reset = 1'b0;
      step();
      n++;
      if (!reset) begin reset = 1'b1; break; end
    end
    if (n >= 40) bound_fail("mid_reset");
    repeat (3) step();
    post(0, 5, 3);
    drain("after_reset", 30);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && ($urandom % 4) == 0)
          post(k, int'($urandom_range(NPAIR - 1, 0)), int'($urandom_range(6, 0)));
      end
      mem_ready = ($urandom % 4) != 0;
      step();
    end
    mem_ready = 1'b1;
    drain("random_drain", 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
